// File: rtl/mem_req_sequencer.sv
// Request front-end for a single-port synchronous memory: issues one access per cycle,
// queues read data in a 2-entry in-order response FIFO, and runs a whole-array fill engine.
module mem_req_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    input  logic                  i_fill_start,
    input  logic [DATA_WIDTH-1:0] i_fill_value,
    output logic                  o_busy,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

    typedef enum logic {StIdle, StFill} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [DATA_WIDTH-1:0] r_fill_value;

    logic                  w_rsp_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_credit;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;

    // Credit counts queued plus in-flight responses, net of this cycle's pop, so a
    // newly accepted read always finds a free FIFO slot when its data arrives.
    assign w_rsp_valid = (r_count != 2'd0);
    assign w_pop       = w_rsp_valid & i_rsp_ready;
    assign w_push      = r_pend;
    assign w_credit    = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_req_ready = (r_state == StIdle) & ~i_fill_start & ~i_rst & (w_credit < 3'd2);
    assign w_accept    = i_req_valid & w_req_ready;

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_din    = '0;
        unique case (r_state)
            StIdle: begin
                if (i_fill_start) begin
                    w_state_next = StFill;
                end
                if (w_accept) begin
                    w_mem_we   = i_req_we;
                    w_mem_addr = i_req_addr;
                    w_mem_din  = i_req_wdata;
                end
            end
            StFill: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_fill_cnt;
                w_mem_din  = r_fill_value;
                if (r_fill_cnt == LastAddr) begin
                    w_state_next = StIdle;
                end
            end
        endcase
        // Reset must stop a fill write in the very cycle it is asserted.
        if (i_rst) begin
            w_mem_we   = 1'b0;
            w_mem_addr = '0;
            w_mem_din  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pend       <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_fill_cnt   <= '0;
            r_fill_value <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_accept & ~i_req_we;
            if ((r_state == StIdle) && i_fill_start) begin
                r_fill_value <= i_fill_value;
            end
            if (r_state == StFill) begin
                r_fill_cnt <= r_fill_cnt + ADDR_WIDTH'(1);
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_mem_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_rdata = w_rsp_valid ? r_fifo[r_rd_ptr] : '0;
    assign o_busy      = (r_state == StFill);
    assign o_mem_we    = w_mem_we;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_din   = w_mem_din;

endmodule
